// File: rtl/xor_cipher_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// xor_cipher_ctrl_pkg
// Shared definitions for the XOR cipher sequencer:
//   - 3-bit state encodings for the controller FSM
//   - default key/message and chunk widths
//   - helpers deriving the chunk count and the chunk-counter width
// ---------------------------------------------------------------------------
package xor_cipher_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] KEY_LOAD = 3'd1;
    localparam logic [2:0] READY    = 3'd2;
    localparam logic [2:0] MSG_LOAD = 3'd3;
    localparam logic [2:0] ENC      = 3'd4;
    localparam logic [2:0] CAPTURE  = 3'd5;
    localparam logic [2:0] OUT      = 3'd6;

    localparam int DEF_MSG_SIZE = 8;
    localparam int DEF_CHUNK_W  = 4;

    // Number of chunks that make up one key or one message word.
    function automatic int calcNChunk(input int msgSize, input int chunkW);
        return msgSize / chunkW;
    endfunction

    // Chunk counter width; the extra bit keeps NCHUNK==1 at a legal width.
    function automatic int cntWidth(input int nChunk);
        return $clog2(nChunk) + 1;
    endfunction

endpackage

// File: rtl/xor_cipher_ctrl_chunk_assembler.sv
// ---------------------------------------------------------------------------
// chunk_assembler
// Builds a MSG_SIZE-wide word from CHUNK_W-wide chunks, MSB chunk first.
// Ports:
//   iClk      clock
//   iRst      asynchronous active-low reset (word and counter to 0)
//   iClear    synchronous clear of word and chunk counter
//   iShiftEn  shift iChunk into the low end of the word
//   iChunk    incoming chunk
//   oWord     assembled word
//   oDone     high in the cycle whose shift completes the word
// ---------------------------------------------------------------------------
module chunk_assembler
    import xor_cipher_ctrl_pkg::*;
#(
    parameter int MSG_SIZE = DEF_MSG_SIZE,
    parameter int CHUNK_W  = DEF_CHUNK_W
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iClear,
    input  logic                iShiftEn,
    input  logic [CHUNK_W-1:0]  iChunk,
    output logic [MSG_SIZE-1:0] oWord,
    output logic                oDone
);

    localparam int NCHUNK = calcNChunk(MSG_SIZE, CHUNK_W);
    localparam int CNT_W  = cntWidth(NCHUNK);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    logic [CNT_W-1:0]    chunkCnt;
    logic [MSG_SIZE-1:0] wordShifted;

    // A single-chunk word has no upper bits to carry over.
    generate
        if (NCHUNK == 1) begin : gSingle
            assign wordShifted = iChunk;
        end else begin : gMulti
            assign wordShifted = {oWord[MSG_SIZE-CHUNK_W-1:0], iChunk};
        end
    endgenerate

    assign oDone = iShiftEn && (chunkCnt == LAST_CNT);

    // Shift register plus chunk counter; the counter returns to 0 on the
    // completing shift so it never wraps in the middle of a word.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oWord    <= '0;
            chunkCnt <= '0;
        end else if (iClear) begin
            oWord    <= '0;
            chunkCnt <= '0;
        end else if (iShiftEn) begin
            oWord    <= wordShifted;
            chunkCnt <= oDone ? '0 : chunkCnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/xor_cipher_ctrl.sv
// ---------------------------------------------------------------------------
// xor_cipher_ctrl
// Sequencer for the XOR encryption datapath: assembles a key, then messages,
// from a chunked input stream, fires one encrypt cycle and presents the
// ciphertext on a valid/ready output.
// Ports:
//   iClk, iRst          clock, asynchronous active-low reset
//   iKey_Start          request to (re)load a key
//   iData/iData_Valid   input chunk stream; oData_Ready accepts a chunk
//   oEn/oEncrypt        one-cycle datapath enable and encrypt strobe
//   oKey_Assembled      key to datapath
//   oMessage            message to datapath
//   iCiphertext         registered datapath result
//   oOut_Data/oOut_Valid/iOut_Ready  ciphertext output handshake
//   oKey_Valid          a complete key is held
//   oBusy               controller is neither idle nor ready
// ---------------------------------------------------------------------------
module xor_cipher_ctrl
    import xor_cipher_ctrl_pkg::*;
#(
    parameter int MSG_SIZE = DEF_MSG_SIZE,
    parameter int CHUNK_W  = DEF_CHUNK_W
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iKey_Start,
    input  logic [CHUNK_W-1:0]  iData,
    input  logic                iData_Valid,
    output logic                oData_Ready,
    output logic                oEn,
    output logic                oEncrypt,
    output logic [MSG_SIZE-1:0] oKey_Assembled,
    output logic [MSG_SIZE-1:0] oMessage,
    input  logic [MSG_SIZE-1:0] iCiphertext,
    output logic [MSG_SIZE-1:0] oOut_Data,
    output logic                oOut_Valid,
    input  logic                iOut_Ready,
    output logic                oKey_Valid,
    output logic                oBusy
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] stateNext;

    logic keyClear;
    logic keyShift;
    logic keyDone;
    logic msgShift;
    logic msgDone;

    // Key start wins over a chunk in READY and restarts an in-progress load;
    // it is ignored once a message has started or a result is in flight.
    assign keyClear = iKey_Start &&
                      ((state == IDLE) || (state == KEY_LOAD) || (state == READY));
    assign keyShift = (state == KEY_LOAD) && iData_Valid && !iKey_Start;
    assign msgShift = iData_Valid &&
                      (((state == READY) && !iKey_Start) || (state == MSG_LOAD));

    assign oData_Ready = (state == KEY_LOAD) || (state == READY) || (state == MSG_LOAD);
    assign oEn         = (state == ENC);
    assign oEncrypt    = (state == ENC);
    assign oOut_Valid  = (state == OUT);
    assign oBusy       = (state != IDLE) && (state != READY);

    chunk_assembler #(
        .MSG_SIZE (MSG_SIZE),
        .CHUNK_W  (CHUNK_W)
    ) keyAssembler (
        .iClk     (iClk),
        .iRst     (iRst),
        .iClear   (keyClear),
        .iShiftEn (keyShift),
        .iChunk   (iData),
        .oWord    (oKey_Assembled),
        .oDone    (keyDone)
    );

    // Message words are always completed or aborted by reset, so the
    // message counter only needs the reset to realign.
    chunk_assembler #(
        .MSG_SIZE (MSG_SIZE),
        .CHUNK_W  (CHUNK_W)
    ) msgAssembler (
        .iClk     (iClk),
        .iRst     (iRst),
        .iClear   (1'b0),
        .iShiftEn (msgShift),
        .iChunk   (iData),
        .oWord    (oMessage),
        .oDone    (msgDone)
    );

    // Next-state logic; with one chunk per word the first message chunk
    // already completes the message and goes straight to ENC.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:     if (iKey_Start) stateNext = KEY_LOAD;
            KEY_LOAD: if (keyDone) stateNext = READY;
            READY: begin
                if (iKey_Start) begin
                    stateNext = KEY_LOAD;
                end else if (msgShift) begin
                    stateNext = msgDone ? ENC : MSG_LOAD;
                end
            end
            MSG_LOAD: if (msgDone) stateNext = ENC;
            ENC:      stateNext = CAPTURE;
            CAPTURE:  stateNext = OUT;
            OUT:      if (iOut_Ready) stateNext = READY;
            default:  stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Key-valid flag drops as soon as a (re)load starts and rises on the
    // completing key chunk.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oKey_Valid <= 1'b0;
        end else if (keyClear) begin
            oKey_Valid <= 1'b0;
        end else if (keyDone) begin
            oKey_Valid <= 1'b1;
        end
    end

    // The datapath registers its result at the end of ENC, so it is
    // sampled during CAPTURE and then held for the whole OUT phase.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oOut_Data <= '0;
        end else if (state == CAPTURE) begin
            oOut_Data <= iCiphertext;
        end
    end

endmodule
